sine_phase_folder: RTL and testbench

- Phase-accumulator front end for the quarter-wave sine lookup.
- Keeps a free-running phase that advances by a programmable frequency word on each step strobe.
- Folds the phase into a quarter-wave table index, which it drives to the table, and reads the table result back combinationally.
- Registers a signed full-wave sample with a valid strobe for the downstream audio/graphics consumers of the demo.

---
 rtl/sine_phase_folder.sv | 146 ++++++++++++++
 tb/tb_sine_phase_folder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sine_phase_folder.sv
// ---------------------------------------------------------------------------
// sine_phase_folder
//
// Phase-accumulator front end for a quarter-wave sine lookup table.
//
// A free-running phase advances by freq on every step strobe. On a step, the
// pre-update phase plus phase_offset is folded into a quarter-wave index. The
// index is registered onto table_x. The external table answers combinationally
// on table_y, and one cycle later a signed full-wave sample is registered with
// a single-cycle valid strobe. Throughput is one sample per cycle, with no
// stall and no backpressure.
//
// Parameters
//   PHASE_BITS : accumulator / frequency word / offset width (>= IN_BITS+2)
//   IN_BITS    : quarter-wave table index width
//   OUT_BITS   : quarter-wave table magnitude width (unsigned)
//
// Ports
//   clk          : clock, rising edge
//   reset        : synchronous, active-high; clears all state and drops any
//                  lookup in flight
//   step         : sample the current phase for lookup, then add freq
//   freq         : unsigned phase increment, wraps modulo 2^PHASE_BITS
//   phase_offset : added to the sampled phase only, never accumulated
//   load         : overwrite the phase with load_value (wins over step's add)
//   load_value   : new phase value
//   table_x      : registered folded index driven to the table
//   table_y      : table magnitude for table_x, same cycle
//   phase        : current accumulator value
//   sample       : signed two's-complement full-wave sample (OUT_BITS+1)
//   sample_valid : single-cycle strobe, sample is new this cycle
// ---------------------------------------------------------------------------
module sine_phase_folder #(
    parameter int PHASE_BITS = 16,
    parameter int IN_BITS    = 8,
    parameter int OUT_BITS   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       step,
    input  logic [PHASE_BITS-1:0]      freq,
    input  logic [PHASE_BITS-1:0]      phase_offset,
    input  logic                       load,
    input  logic [PHASE_BITS-1:0]      load_value,
    output logic [IN_BITS-1:0]         table_x,
    input  logic [OUT_BITS-1:0]        table_y,
    output logic [PHASE_BITS-1:0]      phase,
    output logic signed [OUT_BITS:0]   sample,
    output logic                       sample_valid
);

    // Number of phase bits below the quarter-wave index; these are truncated.
    localparam int DROP_BITS = PHASE_BITS - 2 - IN_BITS;

    // Mirror the index in quadrants 1 and 3 so the table only needs the
    // rising quarter. Index 0 in a mirrored quadrant maps to the table top.
    function automatic logic [IN_BITS-1:0] fold_index(
        input logic                 mirror,
        input logic [IN_BITS-1:0]   idx
    );
        return mirror ? ~idx : idx;
    endfunction

    // Apply the half-wave sign to an unsigned magnitude. The magnitude is
    // widened by one zero bit first, so negation can never overflow and a
    // negative zero comes out as plain zero.
    function automatic logic signed [OUT_BITS:0] apply_sign(
        input logic                 neg,
        input logic [OUT_BITS-1:0]  mag
    );
        logic signed [OUT_BITS:0] ext;
        ext = $signed({1'b0, mag});
        return neg ? -ext : ext;
    endfunction

    logic [PHASE_BITS-1:0]      phase_p0;
    logic [PHASE_BITS-1:0]      lookup_p0;
    logic [1:0]                 quad_p0;
    logic [IN_BITS-1:0]         idx_p0;

    logic [IN_BITS-1:0]         x_p1;
    logic                       neg_p1;
    logic                       vld_p1;

    logic signed [OUT_BITS:0]   sample_p2;
    logic                       vld_p2;

    // ---- stage 0: accumulator and phase decode ----------------------------
    // The lookup always uses the phase as it stands before this edge's update,
    // so a simultaneous load does not affect the sample taken on this step.
    always_comb begin
        lookup_p0 = phase_p0 + phase_offset;
        quad_p0   = lookup_p0[PHASE_BITS-1 -: 2];
        // Drop the quadrant bits off the top and the truncated bits off the
        // bottom, leaving exactly IN_BITS of index.
        idx_p0    = IN_BITS'((lookup_p0 << 2) >> (DROP_BITS + 2));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_p0 <= '0;
        end else if (load) begin
            phase_p0 <= load_value;
        end else if (step) begin
            phase_p0 <= phase_p0 + freq;
        end
    end

    // ---- stage 1: folded index to the table -------------------------------
    // table_x only changes on a step, so it stays stable between steps.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_p1   <= '0;
            neg_p1 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= step;
            if (step) begin
                x_p1   <= fold_index(quad_p0[0], idx_p0);
                neg_p1 <= quad_p0[1];
            end
        end
    end

    // ---- stage 2: signed full-wave sample ---------------------------------
    // table_y answers combinationally for x_p1, so it is captured here one
    // cycle after the step. A reset clears vld_p1, so nothing in flight
    // survives it.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_p2 <= '0;
            vld_p2    <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                sample_p2 <= apply_sign(neg_p1, table_y);
            end
        end
    end

    assign phase        = phase_p0;
    assign table_x      = x_p1;
    assign sample       = sample_p2;
    assign sample_valid = vld_p2;

endmodule

// File: tb/tb_sine_phase_folder.sv
// ---------------------------------------------------------------------------
// tb_sine_phase_folder
//
// Bench for sine_phase_folder with a real quarter-wave table attached:
// table_y = round(255 * sin(pi/2 * table_x / 255)).
// A behavioural model predicts phase, table_x, sample and sample_valid from
// plain phase arithmetic and a queue of pending samples. It is compared with
// the outputs on every falling edge. Directed sequences add hand-computed
// literal expectations.
// ---------------------------------------------------------------------------
module tb_sine_phase_folder;

    localparam int PB = 16;
    localparam int IB = 8;
    localparam int OB = 8;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   step = 1'b0;
    logic [PB-1:0]          freq = '0;
    logic [PB-1:0]          phase_offset = '0;
    logic                   load = 1'b0;
    logic [PB-1:0]          load_value = '0;
    logic [IB-1:0]          table_x;
    logic [OB-1:0]          table_y;
    logic [PB-1:0]          phase;
    logic signed [OB:0]     sample;
    logic                   sample_valid;

    int tests = 0;
    int fails = 0;

    logic [OB-1:0] tbl [0:255];

    always #5 clk = ~clk;

    assign table_y = tbl[table_x];

    sine_phase_folder #(.PHASE_BITS(PB), .IN_BITS(IB), .OUT_BITS(OB)) dut (
        .clk          (clk),
        .reset        (reset),
        .step         (step),
        .freq         (freq),
        .phase_offset (phase_offset),
        .load         (load),
        .load_value   (load_value),
        .table_x      (table_x),
        .table_y      (table_y),
        .phase        (phase),
        .sample       (sample),
        .sample_valid (sample_valid)
    );

    task automatic check(input string nm, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int due;
        int val;
    } pend_t;

    pend_t pend[$];
    int    cyc    = 0;
    int    m_phase = 0;
    int    m_tx    = 0;
    int    m_samp  = 0;
    bit    m_vld   = 1'b0;
    bit    chk_en  = 1'b0;
    int    nvld    = 0;

    task automatic model_edge();
        int p, q, i, f, mag;
        cyc++;
        if (reset) begin
            pend.delete();
            m_phase = 0;
            m_tx    = 0;
            m_samp  = 0;
            m_vld   = 1'b0;
            chk_en  = 1'b1;
        end else begin
            m_vld = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                m_vld  = 1'b1;
                m_samp = pend[0].val;
                pend.pop_front();
            end
            if (step) begin
                p    = (m_phase + int'(phase_offset)) % 65536;
                q    = p / 16384;
                i    = (p % 16384) / 64;
                f    = (q % 2 == 1) ? 255 - i : i;
                mag  = int'(tbl[f]);
                m_tx = f;
                pend.push_back('{due: cyc + 1, val: (q >= 2) ? -mag : mag});
            end
            if (load)      m_phase = int'(load_value);
            else if (step) m_phase = (m_phase + int'(freq)) % 65536;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("model_phase",   phase,        m_phase);
            check("model_table_x", table_x,      m_tx);
            check("model_valid",   sample_valid, m_vld);
            check("model_sample",  sample,       m_samp);
            if (sample_valid) nvld++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load a phase, step once, and check the index, the latency and the sample.
    task automatic do_lookup(input string nm, input logic [PB-1:0] v,
                             input int exp_tx, input int exp_s);
        load = 1'b1; load_value = v; step = 1'b0;
        tick();
        load = 1'b0; step = 1'b1;
        tick();
        step = 1'b0;
        check({nm, "_tx"}, table_x, exp_tx);
        check({nm, "_early_valid"}, sample_valid, 0);
        tick();
        check({nm, "_valid"}, sample_valid, 1);
        check({nm, "_sample"}, sample, exp_s);
        tick();
        check({nm, "_valid_drop"}, sample_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 256; k++)
            tbl[k] = OB'($rtoi(255.0 * $sin(3.14159265358979 / 2.0 * real'(k) / 255.0) + 0.5));

        // Reset state.
        reset = 1'b1;
        tick();
        tick();
        check("rst_phase",   phase,        0);
        check("rst_table_x", table_x,      0);
        check("rst_sample",  sample,       0);
        check("rst_valid",   sample_valid, 0);
        reset = 1'b0;

        // Zero phase, zero frequency, twice.
        freq = '0;
        do_lookup("zero1", 16'h0000, 0, 0);
        do_lookup("zero2", 16'h0000, 0, 0);

        // Quadrant folding.
        do_lookup("q0_1000", 16'h1000, 64, 98);
        do_lookup("q1_4000", 16'h4000, 255, 255);
        do_lookup("q2_8000", 16'h8000, 0, 0);
        do_lookup("q3_C000", 16'hC000, 255, -255);
        do_lookup("q3_D000", 16'hD000, 191, -235);

        // Continuous stepping with wrap: 70 steps of 0x0400.
        load = 1'b1; load_value = 16'h0000; freq = 16'h0400;
        tick();
        load = 1'b0;
        nvld = 0;
        step = 1'b1;
        for (int k = 0; k < 70; k++) tick();
        step = 1'b0;
        tick(); tick(); tick();
        check("run_valid_count", nvld, 70);
        check("run_final_phase", phase, 16'h1800);

        // Offset is applied to the lookup only.
        load = 1'b1; load_value = 16'h0000; freq = 16'h0100; phase_offset = 16'h4000;
        tick();
        load = 1'b0; step = 1'b1;
        tick();
        step = 1'b0;
        check("ofs_phase", phase, 16'h0100);
        check("ofs_tx", table_x, 255);
        tick();
        check("ofs_valid", sample_valid, 1);
        check("ofs_sample", sample, 255);
        phase_offset = '0;
        tick();

        // Load and step together: sample uses the old phase, load wins.
        load = 1'b1; load_value = 16'h1000;
        tick();
        load = 1'b1; load_value = 16'h8000; freq = 16'h0100; step = 1'b1;
        tick();
        load = 1'b0; step = 1'b0;
        check("ldstep_phase", phase, 16'h8000);
        check("ldstep_tx", table_x, 64);
        tick();
        check("ldstep_valid", sample_valid, 1);
        check("ldstep_sample", sample, 98);
        tick();

        // Reset the cycle after a step discards the lookup in flight.
        load = 1'b1; load_value = 16'h4000;
        tick();
        load = 1'b0; step = 1'b1;
        tick();
        step = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstflt_valid",   sample_valid, 0);
        check("rstflt_sample",  sample,       0);
        check("rstflt_phase",   phase,        0);
        check("rstflt_table_x", table_x,      0);
        tick();
        check("rstflt_valid2", sample_valid, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
